// File: rtl/uart_tx_fifo_if.sv
// Producer-side and serializer-side handshake of the UART transmit buffer.
// The master modport is the environment (producer plus serializer); the
// slave modport is the buffer itself.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  TxD_busy;
    logic                  TxD_start;
    logic [7:0]            TxD_data;

    modport master (
        output wr_en, wr_data, TxD_busy,
        input  full, empty, count, overflow, TxD_start, TxD_data
    );

    modport slave (
        input  wr_en, wr_data, TxD_busy,
        output full, empty, count, overflow, TxD_start, TxD_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART serializer. Producers write at clock rate;
// the launch FSM hands one byte at a time to the serializer and waits for
// its busy cycle to finish. If busy never rises the byte is dropped after a
// short timeout so a dead serializer cannot wedge the queue.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 3
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1) > 0 ? $clog2(BUSY_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q, count_nxt;
    logic                  full_q, empty_q, overflow_q;
    state_t                state;
    logic [TW-1:0]         tmo;
    logic                  start_q;
    logic [7:0]            data_q;
    logic                  do_wr, do_pop;

    // full/empty come from registered count, so a pop in the same cycle
    // never rescues a write to a full FIFO.
    assign do_wr  = bus.wr_en && !full_q;
    assign do_pop = (state == IDLE) && !empty_q && !bus.TxD_busy;

    // Next occupancy; simultaneous write and pop leaves it unchanged.
    always_comb begin
        count_nxt = count_q;
        if (do_wr && !do_pop)
            count_nxt = count_q + CW'(1);
        else if (!do_wr && do_pop)
            count_nxt = count_q - CW'(1);
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= bus.wr_data;
    end

    // Write pointer, occupancy counter and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.wr_en && full_q;
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
            empty_q <= (count_nxt == '0);
        end
    end

    // Launch FSM: pop, pulse start, wait for busy to rise (or time out),
    // then wait for busy to fall before the next byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            tmo     <= '0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        data_q  <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + 1'b1;
                        start_q <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    tmo     <= TW'(BUSY_TIMEOUT);
                    state   <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.TxD_busy) begin
                        state <= WAIT_LO;
                    end else begin
                        tmo <= tmo - TW'(1);
                        // Byte is abandoned, not retried.
                        if (tmo <= TW'(1))
                            state <= IDLE;
                    end
                end
                WAIT_LO: begin
                    if (!bus.TxD_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.TxD_start = start_q;
    assign bus.TxD_data  = data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a scoreboard queue holds accepted bytes,
// a negedge monitor models the serializer busy line and checks every launch.
module tb_uart_tx_fifo;
    localparam int DEPTH_LOG2   = 4;
    localparam int BUSY_TIMEOUT = 3;
    localparam int DEPTH        = 1 << DEPTH_LOG2;

    logic clk;
    logic rst;
    uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    int         mcnt = 0;
    logic       ovf_exp = 1'b0;
    int         rejects = 0;
    logic [7:0] last_data = 8'h00;
    int         bmode = 0;      // 0: hold busy hold_len cycles, 1: busy forced high, 2: never busy
    int         hold_len = 10;
    int         bcnt = 0;
    logic       gap_chk = 1'b0;
    logic       gap_armed = 1'b0;
    int         cyc = 0;
    int         last_cyc = 0;
    logic       prev_start = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serializer model and output monitor.
    always @(negedge clk) begin
        cyc++;
        if (bus.TxD_start === 1'b1) begin
            check("start_width", {31'd0, prev_start}, 32'd0);
            check("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                last_data = q.pop_front();
                mcnt--;
                check("tx_data", {24'd0, bus.TxD_data}, {24'd0, last_data});
            end
            if (gap_chk && gap_armed)
                check("start_gap", cyc - last_cyc, 2 + BUSY_TIMEOUT);
            gap_armed = gap_chk;
            last_cyc  = cyc;
            if (bmode == 0)
                bcnt = hold_len;
        end else if (bus.TxD_busy === 1'b1) begin
            check("data_stable", {24'd0, bus.TxD_data}, {24'd0, last_data});
        end
        prev_start = bus.TxD_start;
        check("count", {27'd0, bus.count}, mcnt);
        check("empty", {31'd0, bus.empty}, {31'd0, mcnt == 0});
        check("full", {31'd0, bus.full}, {31'd0, mcnt == DEPTH});
        check("overflow", {31'd0, bus.overflow}, {31'd0, ovf_exp});
        check("count_max", {31'd0, bus.count <= DEPTH}, 32'd1);
        ovf_exp = 1'b0;
        if (bmode == 1) begin
            bcnt = 0;
            bus.TxD_busy = 1'b1;
        end else if (bmode == 0 && bcnt > 0) begin
            bus.TxD_busy = 1'b1;
            bcnt--;
        end else begin
            bus.TxD_busy = 1'b0;
        end
    end

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        #1;
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (mcnt < DEPTH) begin
            q.push_back(d);
            mcnt++;
        end else begin
            ovf_exp = 1'b1;
            rejects++;
        end
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_full", {31'd0, bus.full}, 0);
        check("rst_empty", {31'd0, bus.empty}, 1);
        check("rst_count", {27'd0, bus.count}, 0);
        check("rst_overflow", {31'd0, bus.overflow}, 0);
        check("rst_start", {31'd0, bus.TxD_start}, 0);
        check("rst_data", {24'd0, bus.TxD_data}, 0);
        rst = 1'b0;

        // Single byte, idle serializer: start two edges after the write.
        wr(8'hA5);
        @(negedge clk); #1;
        check("t1_empty_fall", {31'd0, bus.empty}, 0);
        check("t1_count1", {27'd0, bus.count}, 1);
        check("t1_no_start_yet", {31'd0, bus.TxD_start}, 0);
        @(negedge clk); #1;
        check("t1_start", {31'd0, bus.TxD_start}, 1);
        check("t1_data", {24'd0, bus.TxD_data}, 8'hA5);
        check("t1_count0", {27'd0, bus.count}, 0);
        @(negedge clk); #1;
        check("t1_start_drop", {31'd0, bus.TxD_start}, 0);
        drain();

        // Fill while busy is stuck high, then overflow once.
        bmode = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) wr(8'(i));
        @(negedge clk); #1;
        check("t2_full", {31'd0, bus.full}, 1);
        check("t2_count16", {27'd0, bus.count}, 16);
        wr(8'hFF);
        @(negedge clk); #1;
        check("t2_overflow_pulse", {31'd0, bus.overflow}, 1);
        check("t2_rejects", rejects, 1);
        @(negedge clk); #1;
        check("t2_overflow_clear", {31'd0, bus.overflow}, 0);

        // Release: 10-cycle busy per byte, all 16 bytes in order.
        hold_len = 10;
        bmode    = 0;
        drain();

        // Pointer wrap with writes interleaved against pops.
        hold_len = 2;
        rejects  = 0;
        for (int i = 0; i < 40; i++) begin
            wr(8'(8'h40 + i));
            repeat (i % 7) @(posedge clk);
        end
        drain();
        check("t4_no_rejects", rejects, 0);

        // Serializer never raises busy: timeout then next launch.
        bmode   = 2;
        gap_chk = 1'b1;
        wr(8'h11);
        wr(8'h22);
        drain();
        gap_chk = 1'b0;

        // Reset while waiting for busy to fall, with bytes queued.
        bmode    = 0;
        hold_len = 10;
        for (int i = 0; i < 6; i++) wr(8'(8'h80 + i));
        repeat (2) @(negedge clk);
        #1;
        check("t6_queued", {27'd0, bus.count}, 5);
        rst = 1'b1;
        q.delete();
        mcnt      = 0;
        ovf_exp   = 1'b0;
        last_data = 8'h00;
        #1;
        check("t6_start", {31'd0, bus.TxD_start}, 0);
        check("t6_empty", {31'd0, bus.empty}, 1);
        check("t6_count", {27'd0, bus.count}, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (25) @(negedge clk);
        wr(8'h3C);
        drain();
        check("final_sb_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
